// File: rtl/adc_capture_pkg.sv
// Shared types and widths for the subsampled ADC capture block.
package adc_capture_pkg;

  localparam int DATA_W          = 14;
  localparam int SAMPLES_PER_SET = 4;
  localparam int ACC_W           = DATA_W + $clog2(SAMPLES_PER_SET);
  localparam int IDX_W           = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/adc_set_accum.sv
// Per-set sample accumulator with round-half-up average of SAMPLES samples.
module adc_set_accum
  import adc_capture_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_PER_SET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] avg
);
  localparam int SH = $clog2(SAMPLES);
  localparam int AW = DATA_W + SH;

  logic [AW-1:0] r_acc;
  logic [AW:0]   w_rnd;

  // clr and add can coincide when a new set's first sample lands on the
  // cycle the previous result is taken; the new sample then seeds the sum.
  always_ff @(posedge clk) begin
    if (rst)      r_acc <= '0;
    else if (clr) r_acc <= add ? AW'(din) : '0;
    else if (add) r_acc <= r_acc + AW'(din);
  end

  assign w_rnd = {1'b0, r_acc} + (AW+1)'(SAMPLES / 2);
  assign avg   = DATA_W'(w_rnd >> SH);

endmodule

// File: rtl/adc_subsample_capture.sv
// Subsampled ADC capture: settle after a trigger, then average NUM_SETS sets
// sampled at shrinking intervals and stream one rounded result per set.
module adc_subsample_capture
  import adc_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 100,
  parameter int BASE_INTERVAL = 20,
  parameter int NUM_SETS      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              abort,
  input  logic [DATA_W-1:0] bn,
  output logic              busy,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic              done
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(BASE_INTERVAL + 1);
  localparam int SW = (SAMPLES_PER_SET > 1) ? $clog2(SAMPLES_PER_SET) : 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  state_t            r_state, w_nx;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_ivl, w_ivl_max;
  logic [SW-1:0]     r_smp;
  logic [IDX_W-1:0]  r_set, r_pidx;
  logic              r_pend, r_pend_last;
  logic              w_sample, w_set_end, w_emit, w_finish, w_clr;
  logic [DATA_W-1:0] w_avg;

  assign w_ivl_max = IW'(BASE_INTERVAL - 1) - IW'(r_set);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nx;
  end

  always_comb begin
    w_nx      = r_state;
    w_sample  = 1'b0;
    w_set_end = 1'b0;
    w_emit    = 1'b0;
    w_finish  = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      IDLE: if (trigger) w_nx = SETTLE;
      SETTLE: begin
        if (abort) begin
          w_nx  = IDLE;
          w_clr = 1'b1;
        end else if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
          w_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          w_nx  = IDLE;
          w_clr = 1'b1;
        end else begin
          // A completed set is reported one cycle after its last sample.
          w_emit   = r_pend;
          w_clr    = r_pend;
          w_finish = r_pend && r_pend_last;
          if (w_finish) begin
            w_nx = IDLE;
          end else if (r_ivl == w_ivl_max) begin
            w_sample  = 1'b1;
            w_set_end = (r_smp == SW'(SAMPLES_PER_SET - 1));
          end
        end
      end
      default: w_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_ivl       <= '0;
      r_smp       <= '0;
      r_set       <= '0;
      r_pidx      <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      res_data    <= '0;
      done        <= 1'b0;
    end else begin
      r_cnt <= (r_state == SETTLE) ? r_cnt + 1'b1 : '0;
      // Interval counter restarts after every sample, including across sets.
      r_ivl <= (r_state != CAPTURE || w_sample) ? '0 : r_ivl + 1'b1;
      if (r_state != CAPTURE) begin
        r_smp <= '0;
        r_set <= '0;
      end else if (w_sample) begin
        r_smp <= w_set_end ? '0 : r_smp + 1'b1;
        if (w_set_end && r_set != LAST_SET) r_set <= r_set + 1'b1;
      end
      r_pend      <= w_set_end;
      r_pend_last <= w_set_end && (r_set == LAST_SET);
      if (w_set_end) r_pidx <= r_set;
      busy      <= (w_nx != IDLE);
      res_valid <= w_emit;
      done      <= w_finish;
      if (w_emit) begin
        res_idx  <= r_pidx;
        res_data <= w_avg;
      end
    end
  end

  adc_set_accum #(.SAMPLES(SAMPLES_PER_SET)) u_accum (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .add (w_sample),
    .din (bn),
    .avg (w_avg)
  );

endmodule

// File: tb/tb_adc_subsample_capture.sv
// Randomized bench for adc_subsample_capture; expected results come from the
// sample-time formula and a per-edge record of the driven ADC bus.
module tb_adc_subsample_capture;
  localparam int SETTLE = 100, BASE = 20, NS = 5, SPS = 4, WIN = 480;

  logic        clk = 1'b0, rst = 1'b1, trigger = 1'b0, abort = 1'b0;
  logic [13:0] bn;
  logic        busy, res_valid, done;
  logic [2:0]  res_idx;
  logic [13:0] res_data;

  adc_subsample_capture #(.SETTLE_CYCLES(SETTLE), .BASE_INTERVAL(BASE), .NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .bn(bn),
    .busy(busy), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data), .done(done));

  always #5 clk = ~clk;

  // cyc == index of the most recent rising edge (first edge is 1)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // bus stimulus: 0 const, 1 ramp (edge - t0), 2 random, 3 step 1->2 at t0+thr
  int mode = 0, konst = 0, t0 = 0, thr = 0, bnv;
  int bn_hist[int];
  always @(negedge clk) begin
    case (mode)
      0:       bnv = konst;
      1:       bnv = (cyc + 1 - t0) & 16'h3fff;
      2:       bnv = int'($urandom_range(0, 16383));
      default: bnv = ((cyc + 1 - t0) < thr) ? 1 : 2;
    endcase
    bn = 14'(bnv);
    bn_hist[cyc + 1] = bnv;
  end

  typedef struct {int e; int idx; int d; bit dn;} ev_t;
  ev_t ev;
  ev_t q[$];
  int  done_q[$];
  always @(negedge clk) begin
    if (res_valid) begin
      ev.e = cyc; ev.idx = int'(res_idx); ev.d = int'(res_data); ev.dn = done;
      q.push_back(ev);
    end
    if (done) done_q.push_back(cyc);
  end

  // reference: sample edges and averages straight from the capture rules
  int exp_e[NS], exp_d[NS];
  function automatic void model(input int t);
    int e, s;
    e = t + SETTLE;
    for (int k = 0; k < NS; k++) begin
      s = 0;
      for (int j = 0; j < SPS; j++) begin
        e += BASE - k;
        s += bn_hist[e];
      end
      exp_e[k] = e + 1;
      exp_d[k] = (s + SPS / 2) / SPS;
    end
  endfunction

  int obs_n, dn_n, dn_e;
  int obs_e[8], obs_i[8], obs_d[8];
  bit obs_dn[8];
  function automatic void collect(input int t);
    obs_n = 0; dn_n = 0; dn_e = -1;
    foreach (q[m]) if (q[m].e > t && q[m].e <= t + WIN) begin
      if (obs_n < 8) begin
        obs_e[obs_n] = q[m].e; obs_i[obs_n] = q[m].idx;
        obs_d[obs_n] = q[m].d; obs_dn[obs_n] = q[m].dn;
      end
      obs_n++;
    end
    foreach (done_q[m]) if (done_q[m] > t && done_q[m] <= t + WIN) begin
      if (dn_n == 0) dn_e = done_q[m];
      dn_n++;
    end
  endfunction

  task automatic wait_to(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  task automatic start_run(output int t);
    @(negedge clk);
    trigger = 1'b1; t = cyc + 1; t0 = t;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, res_valid, done, res_idx, res_data} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy %b vld %b done %b idx %0d data %0d, want all 0",
               busy, res_valid, done, res_idx, res_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_const();
    int t;
    mode = 0; konst = 1000;
    start_run(t);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL const_busy_start: got %b want 1", busy); end
    wait_to(t + WIN);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL const_busy_end: got %b want 0", busy); end
    collect(t); model(t);
    n_chk++;
    if (obs_n !== NS || dn_n !== 1) begin
      n_fail++; $display("FAIL const_count: got %0d results/%0d done, want %0d/1", obs_n, dn_n, NS);
    end
    n_chk++;
    if (dn_e !== t + 461) begin n_fail++; $display("FAIL const_done_edge: got T+%0d want T+461", dn_e - t); end
    for (int k = 0; k < NS && k < obs_n; k++) begin
      n_chk++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== k || obs_d[k] !== 1000 || obs_dn[k] !== (k == NS-1)) begin
        n_fail++;
        $display("FAIL const_set%0d: got T+%0d idx %0d data %0d done %0d, want T+%0d idx %0d data 1000",
                 k, obs_e[k] - t, obs_i[k], obs_d[k], obs_dn[k], exp_e[k] - t, k);
      end
    end
  endtask

  task automatic test_ramp();
    int t;
    mode = 1;
    start_run(t);
    wait_to(t + WIN);
    collect(t); model(t);
    n_chk++;
    if (obs_d[0] !== 150 || obs_d[1] !== 228) begin
      n_fail++; $display("FAIL ramp_sets01: got %0d,%0d want 150,228", obs_d[0], obs_d[1]);
    end
    n_chk++;
    if (obs_n !== NS || dn_n !== 1) begin
      n_fail++; $display("FAIL ramp_count: got %0d results/%0d done, want %0d/1", obs_n, dn_n, NS);
    end
    for (int k = 0; k < NS && k < obs_n; k++) begin
      n_chk++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== k || obs_d[k] !== exp_d[k] || obs_dn[k] !== (k == NS-1)) begin
        n_fail++;
        $display("FAIL ramp_set%0d: got T+%0d idx %0d data %0d, want T+%0d idx %0d data %0d",
                 k, obs_e[k] - t, obs_i[k], obs_d[k], exp_e[k] - t, k, exp_d[k]);
      end
    end
  endtask

  int rd_exp[3] = '{2, 1, 16383};
  task automatic test_rounding();
    int t;
    for (int p = 0; p < 3; p++) begin
      if (p == 2) begin mode = 0; konst = 16383; end
      else begin mode = 3; thr = (p == 0) ? 130 : 170; end
      start_run(t);
      wait_to(t + WIN);
      collect(t); model(t);
      n_chk++;
      if (obs_n !== NS || obs_d[0] !== rd_exp[p]) begin
        n_fail++; $display("FAIL round%0d_set0: got %0d results data %0d, want %0d results data %0d",
                           p, obs_n, obs_d[0], NS, rd_exp[p]);
      end
      for (int k = 1; k < NS && k < obs_n; k++) begin
        n_chk++;
        if (obs_d[k] !== exp_d[k] || obs_i[k] !== k) begin
          n_fail++; $display("FAIL round%0d_set%0d: got idx %0d data %0d, want idx %0d data %0d",
                             p, k, obs_i[k], obs_d[k], k, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, t2;
    mode = 2;
    start_run(t);
    wait_to(t + 49);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    while (!done && cyc < t + WIN) @(negedge clk);
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_seen: got %b want 1", done); end
    trigger = 1'b1; t2 = cyc + 1; t0 = t2;
    @(negedge clk);
    trigger = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_retrigger_busy: got %b want 1", busy); end
    wait_to(t2 + WIN);
    for (int r = 0; r < 2; r++) begin
      collect(r == 0 ? t : t2); model(r == 0 ? t : t2);
      n_chk++;
      if (obs_n !== NS || dn_n !== 1) begin
        n_fail++; $display("FAIL b2b_run%0d_count: got %0d results/%0d done, want %0d/1", r, obs_n, dn_n, NS);
      end
      for (int k = 0; k < NS && k < obs_n; k++) begin
        n_chk++;
        if (obs_e[k] !== exp_e[k] || obs_i[k] !== k || obs_d[k] !== exp_d[k] || obs_dn[k] !== (k == NS-1)) begin
          n_fail++;
          $display("FAIL b2b_run%0d_set%0d: got edge %0d idx %0d data %0d, want edge %0d idx %0d data %0d",
                   r, k, obs_e[k], obs_i[k], obs_d[k], exp_e[k], k, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int t;
    mode = 2;
    @(negedge clk);
    trigger = 1'b1; abort = 1'b1; t = cyc + 1;
    @(negedge clk);
    trigger = 1'b0; abort = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_trig_wins: got busy %b want 1", busy); end
    wait_to(t + 249);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    wait_to(t + WIN);
    collect(t); model(t);
    n_chk++;
    if (obs_n !== 1 || dn_n !== 0 || obs_d[0] !== exp_d[0] || obs_e[0] !== exp_e[0]) begin
      n_fail++; $display("FAIL abort_partial: got %0d results/%0d done data0 %0d, want 1/0 data0 %0d",
                         obs_n, dn_n, obs_d[0], exp_d[0]);
    end
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy %b want 0", busy); end
    mode = 1;
    start_run(t);
    wait_to(t + WIN);
    collect(t); model(t);
    n_chk++;
    if (obs_n !== NS || dn_n !== 1) begin
      n_fail++; $display("FAIL abort_rerun_count: got %0d results/%0d done, want %0d/1", obs_n, dn_n, NS);
    end
    for (int k = 0; k < NS && k < obs_n; k++) begin
      n_chk++;
      if (obs_i[k] !== k || obs_d[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL abort_rerun_set%0d: got idx %0d data %0d, want idx %0d data %0d",
                           k, obs_i[k], obs_d[k], k, exp_d[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    mode = 2;
    start_run(t);
    wait_to(t + 299);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, res_valid, done, res_idx, res_data} !== 17'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy %b vld %b done %b idx %0d data %0d, want all 0",
                         busy, res_valid, done, res_idx, res_data);
    end
    rst = 1'b0;
    wait_to(t + WIN);
    collect(t); model(t);
    n_chk++;
    if (obs_n !== 2 || dn_n !== 0) begin
      n_fail++; $display("FAIL rstmid_count: got %0d results/%0d done, want 2/0", obs_n, dn_n);
    end
    start_run(t);
    wait_to(t + WIN);
    collect(t); model(t);
    n_chk++;
    if (obs_n !== NS || dn_n !== 1) begin
      n_fail++; $display("FAIL rstmid_rerun_count: got %0d results/%0d done, want %0d/1", obs_n, dn_n, NS);
    end
    for (int k = 0; k < NS && k < obs_n; k++) begin
      n_chk++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== k || obs_d[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL rstmid_rerun_set%0d: got T+%0d idx %0d data %0d, want T+%0d idx %0d data %0d",
                           k, obs_e[k] - t, obs_i[k], obs_d[k], exp_e[k] - t, k, exp_d[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ramp();
    test_rounding();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1);
  end

endmodule
